// File: rtl/regfile_master_if.sv
// regfile_master_if
//   Bundles the request channel, the response channel and the register file
//   pins of regfile_master into one interface.
//
//   Request channel : req_valid, req_ready, req_write, req_addr, req_wdata
//   Response channel: rsp_valid, rsp_ready, rsp_rdata, rsp_err
//   Register file   : mem_wr_en, mem_rd_en, mem_address, mem_in_data,
//                     mem_out_data, mem_valid_out
//
//   Handshake rule for both channels: a transfer happens on a rising edge
//   where valid and ready are both 1. The producer holds valid and its
//   payload stable until that edge, and valid does not depend on ready.
//
//   modport master: the view taken by regfile_master.
//   modport slave : the opposite view (sequencer, consumer and register file).
interface regfile_master_if #(
  parameter int WIDTH   = 32,
  parameter int ADDRESS = 4
);
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [ADDRESS-1:0] req_addr;
  logic [WIDTH-1:0]   req_wdata;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_rdata;
  logic               rsp_err;

  logic               mem_wr_en;
  logic               mem_rd_en;
  logic [ADDRESS-1:0] mem_address;
  logic [WIDTH-1:0]   mem_in_data;
  logic [WIDTH-1:0]   mem_out_data;
  logic               mem_valid_out;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  rsp_ready,
    input  mem_out_data, mem_valid_out,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output mem_wr_en, mem_rd_en, mem_address, mem_in_data
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output rsp_ready,
    output mem_out_data, mem_valid_out,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  mem_wr_en, mem_rd_en, mem_address, mem_in_data
  );
endinterface

// File: rtl/regfile_master.sv
// regfile_master
//   Initiator for the on-chip register file. Takes one read or write request
//   at a time, drives the register file pins for exactly one cycle per
//   access, captures the registered read data and returns one response.
//
// Ports
//   clk         : rising-edge clock
//   rst         : asynchronous active-high reset
//   bus         : regfile_master_if.master (request, response, register file)
//   o_dbg_state : current FSM state (IDLE=0, WR=1, RD=2, CAP=3, RSP=4)
//
// Build option
//   REGFILE_MASTER_WR_VERIFY_EN : when defined, every write is followed by a
//   readback of the same address; the response carries the read-back data
//   and flags an error if it differs from the written data.
//
// Every output is a register. The output process computes the value each
// output register takes on the next edge, from the current state and inputs.
module regfile_master #(
  parameter int WIDTH   = 32,
  parameter int ADDRESS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_master_if.master       bus,
  output logic [2:0]             o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_RSP  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic               r_req_ready,   w_req_ready;
  logic               r_rsp_valid,   w_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_rdata,   w_rsp_rdata;
  logic               r_rsp_err,     w_rsp_err;
  logic               r_mem_wr_en,   w_mem_wr_en;
  logic               r_mem_rd_en,   w_mem_rd_en;
  logic [ADDRESS-1:0] r_mem_address, w_mem_address;
  logic [WIDTH-1:0]   r_mem_in_data, w_mem_in_data;
`ifdef REGFILE_MASTER_WR_VERIFY_EN
  // Tells CAP whether it is finishing a read or a write readback.
  logic               r_is_write,    w_is_write;
`endif

  logic               w_req_fire;
  logic               w_rsp_fire;

  assign w_req_fire = r_req_ready & bus.req_valid;
  assign w_rsp_fire = r_rsp_valid & bus.rsp_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req_fire) w_next = bus.req_write ? S_WR : S_RD;
`ifdef REGFILE_MASTER_WR_VERIFY_EN
      S_WR:   w_next = S_RD;
`else
      S_WR:   w_next = S_RSP;
`endif
      S_RD:   w_next = S_CAP;
      S_CAP:  w_next = S_RSP;
      S_RSP:  if (w_rsp_fire) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic: next values of the output registers.
  always_comb begin
    w_rsp_valid   = r_rsp_valid;
    w_rsp_rdata   = r_rsp_rdata;
    w_rsp_err     = r_rsp_err;
    w_mem_address = r_mem_address;
    w_mem_in_data = r_mem_in_data;
    w_mem_wr_en   = 1'b0;
    w_mem_rd_en   = 1'b0;
`ifdef REGFILE_MASTER_WR_VERIFY_EN
    w_is_write    = r_is_write;
`endif
    // Registered ready: it rises on the edge that enters IDLE, so it is
    // 0 while reset is held and rises one edge after release.
    w_req_ready   = (w_next == S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_req_fire) begin
          w_mem_address = bus.req_addr;
`ifdef REGFILE_MASTER_WR_VERIFY_EN
          w_is_write    = bus.req_write;
`endif
          if (bus.req_write) begin
            w_mem_wr_en   = 1'b1;
            w_mem_in_data = bus.req_wdata;
          end else begin
            w_mem_rd_en   = 1'b1;
          end
        end
      end
      S_WR: begin
`ifdef REGFILE_MASTER_WR_VERIFY_EN
        // Readback of the address just written; mem_address is unchanged.
        w_mem_rd_en = 1'b1;
`else
        w_rsp_valid = 1'b1;
        w_rsp_rdata = '0;
        w_rsp_err   = 1'b0;
`endif
      end
      S_CAP: begin
        // mem_out_data was updated by the register file on the previous edge.
        w_rsp_valid = 1'b1;
        w_rsp_rdata = bus.mem_out_data;
`ifdef REGFILE_MASTER_WR_VERIFY_EN
        // mem_in_data still holds the write data of this request.
        if (r_is_write) begin
          w_rsp_err = (bus.mem_out_data != r_mem_in_data) | ~bus.mem_valid_out;
        end else begin
          w_rsp_err = ~bus.mem_valid_out;
        end
`else
        w_rsp_err   = ~bus.mem_valid_out;
`endif
      end
      S_RSP: begin
        if (w_rsp_fire) w_rsp_valid = 1'b0;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_mem_wr_en   <= 1'b0;
      r_mem_rd_en   <= 1'b0;
      r_mem_address <= '0;
      r_mem_in_data <= '0;
`ifdef REGFILE_MASTER_WR_VERIFY_EN
      r_is_write    <= 1'b0;
`endif
    end else begin
      r_req_ready   <= w_req_ready;
      r_rsp_valid   <= w_rsp_valid;
      r_rsp_rdata   <= w_rsp_rdata;
      r_rsp_err     <= w_rsp_err;
      r_mem_wr_en   <= w_mem_wr_en;
      r_mem_rd_en   <= w_mem_rd_en;
      r_mem_address <= w_mem_address;
      r_mem_in_data <= w_mem_in_data;
`ifdef REGFILE_MASTER_WR_VERIFY_EN
      r_is_write    <= w_is_write;
`endif
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.mem_wr_en   = r_mem_wr_en;
  assign bus.mem_rd_en   = r_mem_rd_en;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_in_data = r_mem_in_data;
  assign o_dbg_state     = r_state;

endmodule

// File: doc/regfile_master.md
# regfile_master

Initiator for the on-chip register file. Accepts single read/write requests on a valid/ready request channel, drives the register file's `wr_en`/`rd_en`/`address`/`in_data` pins, and captures `out_data`/`valid_out`. Returns one response per request on a valid/ready response channel. Sits between the bus/test sequencer side and the register file instance.

## Interface
- `WIDTH`, 32, data width; must match the register file.
- `ADDRESS`, 4, address width; must match the register file.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDRESS: target word.
- `req_wdata` in WIDTH: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_rdata` out WIDTH: read data; 0 for writes.
- `rsp_err` out 1: response error flag.
- `mem_wr_en` out 1: register file write enable.
- `mem_rd_en` out 1: register file read enable.
- `mem_address` out ADDRESS: register file address.
- `mem_in_data` out WIDTH: register file write data.
- `mem_out_data` in WIDTH: register file read data, registered, valid one edge after `mem_rd_en`.
- `mem_valid_out` in 1: register file read-valid flag. Sticky: set by a read, cleared by a write.

## Operation
- The FSM has states IDLE, WR, RD, CAP, and RSP. All outputs are registered.
- In IDLE, `req_ready` = 1. A handshake (`req_valid & req_ready`) latches `req_write`, `req_addr`, and `req_wdata`.
  - Write: next state is WR, with `mem_wr_en` <= 1, `mem_address`, and `mem_in_data` loaded.
  - Read: next state is RD, with `mem_rd_en` <= 1 and `mem_address` loaded.
- WR is one cycle with `mem_wr_en` high. On the next edge, `mem_wr_en` <= 0.
  - The block goes to RSP with `rsp_valid` <= 1, `rsp_rdata` <= 0, and `rsp_err` <= 0.
  - With verify compiled in, see Configuration.
- RD is one cycle with `mem_rd_en` high. On the next edge, `mem_rd_en` <= 0 and the block goes to CAP.
- In CAP, the block samples `mem_out_data` into `rsp_rdata`.
  - `rsp_err` <= ~`mem_valid_out`.
  - `rsp_valid` <= 1, then the block goes to RSP.
- RSP holds `rsp_valid`, `rsp_rdata`, and `rsp_err` stable until `rsp_ready`. On the edge with `rsp_valid & rsp_ready`, `rsp_valid` <= 0 and the block goes to IDLE.
- `mem_wr_en` and `mem_rd_en` are never high in the same cycle. Each is high for exactly one cycle per access.
- `req_ready` is 0 in every state except IDLE. No request queuing and no outstanding-request overlap.
- `mem_address` and `mem_in_data` hold their last values when idle.
- Reset (`rst` = 1, at any time) has immediate effect:
  - Outputs: `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, `mem_wr_en` = 0, `mem_rd_en` = 0, `mem_address` = 0, `mem_in_data` = 0.
  - State goes to IDLE.
  - An in-flight request is dropped with no response.
  - `req_ready` rises on the first edge after `rst` falls.

## Timing
- Edge 0 is the request handshake edge.
- Write, no verify: `mem_wr_en` is high between edge 0 and edge 1. `rsp_valid` is high after edge 1 (1-cycle latency).
- Read: `mem_rd_en` is high between edge 0 and edge 1. The register file updates `out_data` at edge 1. The block samples at edge 2, and `rsp_valid` is high after edge 2 (2-cycle latency).
- Verified write: `rsp_valid` is high after edge 3.
- If `rsp_ready` is held high, `req_ready` returns one cycle after the response handshake.
  - Maximum throughput is one read per 4 cycles and one write per 3 cycles.

## Configuration
- The macro is `REGFILE_MASTER_WR_VERIFY_EN`.
- Defined: every write is followed by an automatic readback.
  - WR goes to RD (not RSP), issuing `mem_rd_en` to the same address.
  - In CAP, `rsp_rdata` <= `mem_out_data`.
  - `rsp_err` <= (`mem_out_data` != latched wdata) | ~`mem_valid_out`.
- Undefined: writes respond directly from WR with `rsp_err` = 0. No readback logic is synthesized.

## Test plan
- Reset check: assert `rst` mid-read (during RD).
  - Required: all outputs go to 0 immediately.
  - Required: no `rsp_valid` after release.
  - Required: `req_ready` = 1 one edge after release.
- Write 0xDEADBEEF to addr 3 (verify off).
  - Required: `mem_wr_en` is high for exactly 1 cycle with `mem_address` = 3 and `mem_in_data` = 0xDEADBEEF.
  - Required: response after 1 cycle with `rsp_rdata` = 0 and `rsp_err` = 0.
- Write 0x12345678 to addr 15, then read addr 15.
  - Required: `rsp_rdata` = 0x12345678, `rsp_err` = 0, `rsp_valid` 2 cycles after the read handshake.
- Read addr 7 right after reset.
  - Required: `rsp_rdata` = 0, `rsp_err` = 0.
  - Required: `mem_wr_en` and `mem_rd_en` never high in the same cycle.
- Backpressure: hold `rsp_ready` = 0 for 5 cycles with read data 0xA5A5A5A5 pending.
  - Required: `rsp_valid` and `rsp_rdata` stay stable and `req_ready` stays 0.
  - Required: the response is consumed on the first cycle `rsp_ready` = 1.
- With `REGFILE_MASTER_WR_VERIFY_EN`, write 0xCAFE0001 to addr 9.
  - Required: `rsp_rdata` = 0xCAFE0001 and `rsp_err` = 0 at 3-cycle latency.
  - With a bench-forced corrupted `mem_out_data` of 0xCAFE0000, required `rsp_err` = 1.
